// File: rtl/pcie_tx_merge_if.sv
// Bundle of the merge block's source, sink and status signals.
// Sources write with a push strobe and have no ready. S*_pause is an early warning and wr_error flags dropped words.
// The sink sees push_out as valid, with pause_in acting as its inverted ready.
interface pcie_tx_merge_if #(
  parameter int BITNUMBER = 6
);
  logic [BITNUMBER-1:0] data_in0;
  logic                 push0;
  logic [BITNUMBER-1:0] data_in1;
  logic                 push1;
  logic                 pause_in;
  logic [BITNUMBER-1:0] data_out;
  logic                 push_out;
  logic                 S0_pause;
  logic                 S1_pause;
  logic                 S0_wr_error;
  logic                 S1_wr_error;
  logic                 last_grant_dbg;

  modport slave (
    input  data_in0, push0, data_in1, push1, pause_in,
    output data_out, push_out, S0_pause, S1_pause, S0_wr_error, S1_wr_error,
           last_grant_dbg
  );

  modport master (
    output data_in0, push0, data_in1, push1, pause_in,
    input  data_out, push_out, S0_pause, S1_pause, S0_wr_error, S1_wr_error,
           last_grant_dbg
  );
endinterface

// File: rtl/pcie_tx_merge.sv
// Two circular source FIFOs merged into one registered output stream.
// Arbitration is round-robin on the last granted source and is gated by downstream pause.
module pcie_tx_merge #(
  parameter int BITNUMBER = 6,
  parameter int LENGTH    = 4,
  parameter int UMBRAL    = 1
) (
  input  logic             clk,
  input  logic             reset,
  pcie_tx_merge_if.slave   bus
);
  localparam int PW = $clog2(LENGTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(LENGTH);
  localparam logic [CW-1:0] PAUSE_CNT = CW'(LENGTH - UMBRAL);

  typedef enum logic {GRANT_S0 = 1'b0, GRANT_S1 = 1'b1} grant_e;

  grant_e               last_grant_q, last_grant_d;
  logic [BITNUMBER-1:0] mem0_q [LENGTH];
  logic [BITNUMBER-1:0] mem1_q [LENGTH];
  logic [PW-1:0]        wr0_q, wr0_d, rd0_q, rd0_d;
  logic [PW-1:0]        wr1_q, wr1_d, rd1_q, rd1_d;
  logic [CW-1:0]        cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;
  logic [BITNUMBER-1:0] data_out_q, data_out_d;
  logic                 push_out_q, push_out_d;
  logic                 elig0, elig1, pop0, pop1, acc0, acc1;

  // Arbiter: the source not granted last time wins a tie.
  always_comb begin
    elig0        = (cnt0_q != '0);
    elig1        = (cnt1_q != '0);
    pop0         = 1'b0;
    pop1         = 1'b0;
    last_grant_d = last_grant_q;
    if (!bus.pause_in) begin
      if (elig0 && (!elig1 || last_grant_q == GRANT_S1)) begin
        pop0         = 1'b1;
        last_grant_d = GRANT_S0;
      end else if (elig1) begin
        pop1         = 1'b1;
        last_grant_d = GRANT_S1;
      end
    end
  end

  // A full FIFO still accepts a push when it is popped on the same edge.
  always_comb begin
    acc0       = bus.push0 && ((cnt0_q != FULL_CNT) || pop0);
    acc1       = bus.push1 && ((cnt1_q != FULL_CNT) || pop1);
    wr0_d      = acc0 ? wr0_q + PW'(1) : wr0_q;
    wr1_d      = acc1 ? wr1_q + PW'(1) : wr1_q;
    rd0_d      = pop0 ? rd0_q + PW'(1) : rd0_q;
    rd1_d      = pop1 ? rd1_q + PW'(1) : rd1_q;
    cnt0_d     = cnt0_q + CW'(acc0) - CW'(pop0);
    cnt1_d     = cnt1_q + CW'(acc1) - CW'(pop1);
    err0_d     = err0_q | (bus.push0 & ~acc0);
    err1_d     = err1_q | (bus.push1 & ~acc1);
    push_out_d = pop0 | pop1;
    data_out_d = data_out_q;
    if (pop0) begin
      data_out_d = mem0_q[rd0_q];
    end else if (pop1) begin
      data_out_d = mem1_q[rd1_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GRANT_S1;
      wr0_q        <= '0;
      rd0_q        <= '0;
      wr1_q        <= '0;
      rd1_q        <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      data_out_q   <= '0;
      push_out_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr0_q        <= wr0_d;
      rd0_q        <= rd0_d;
      wr1_q        <= wr1_d;
      rd1_q        <= rd1_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      data_out_q   <= data_out_d;
      push_out_q   <= push_out_d;
    end
  end

  // Storage is not reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (acc0) mem0_q[wr0_q] <= bus.data_in0;
    if (acc1) mem1_q[wr1_q] <= bus.data_in1;
  end

  assign bus.data_out       = data_out_q;
  assign bus.push_out       = push_out_q;
  assign bus.S0_pause       = (cnt0_q >= PAUSE_CNT);
  assign bus.S1_pause       = (cnt1_q >= PAUSE_CNT);
  assign bus.S0_wr_error    = err0_q;
  assign bus.S1_wr_error    = err1_q;
  assign bus.last_grant_dbg = last_grant_q;
endmodule

// File: tb/tb_pcie_tx_merge.sv
// Bench for pcie_tx_merge: directed scenarios plus random traffic, checked against a queue-based model.
module tb_pcie_tx_merge;
  localparam int W = 6;
  localparam int L = 4;
  localparam int U = 1;

  logic clk = 1'b0;
  logic reset;

  pcie_tx_merge_if #(.BITNUMBER(W)) bus ();

  pcie_tx_merge #(.BITNUMBER(W), .LENGTH(L), .UMBRAL(U)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: per-source queues, last winner, sticky errors
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] exp_q[$];
  int           last_g;
  logic         m_push_out;
  logic [W-1:0] m_data_out;
  logic         m_err0, m_err1;
  logic         seen_3f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    exp_q.delete();
    last_g     = 1;
    m_push_out = 1'b0;
    m_data_out = '0;
    m_err0     = 1'b0;
    m_err1     = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    bus.push0    = 1'b0;
    bus.push1    = 1'b0;
    bus.pause_in = 1'b0;
    #1;
    chk("rst_push_out", 32'(bus.push_out), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_err0", 32'(bus.S0_wr_error), 32'd0);
    chk("rst_err1", 32'(bus.S1_wr_error), 32'd0);
    chk("rst_pause0", 32'(bus.S0_pause), 32'd0);
    chk("rst_grant", 32'(bus.last_grant_dbg), 32'd1);
    chk("sb_left_before_rst", 32'(exp_q.size()), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_outputs();
    chk("push_out", 32'(bus.push_out), 32'(m_push_out));
    chk("data_out", 32'(bus.data_out), 32'(m_data_out));
    chk("s0_pause", 32'(bus.S0_pause), 32'(q0.size() >= L - U));
    chk("s1_pause", 32'(bus.S1_pause), 32'(q1.size() >= L - U));
    chk("s0_err", 32'(bus.S0_wr_error), 32'(m_err0));
    chk("s1_err", 32'(bus.S1_wr_error), 32'(m_err1));
    chk("last_grant", 32'(bus.last_grant_dbg), 32'(last_g));
    if (bus.push_out === 1'b1) begin
      if (bus.data_out == 6'h3F) seen_3f = 1'b1;
      if (exp_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("sb_order", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
  endtask

  // driver: one clock cycle of stimulus, model step, then check after the edge
  task automatic step(input logic p0, input logic [W-1:0] d0,
                      input logic p1, input logic [W-1:0] d1, input logic pa);
    int           g;
    bit           full0, full1;
    logic [W-1:0] w;
    @(negedge clk);
    bus.push0    = p0;
    bus.data_in0 = d0;
    bus.push1    = p1;
    bus.data_in1 = d1;
    bus.pause_in = pa;
    full0 = (q0.size() == L);
    full1 = (q1.size() == L);
    g = -1;
    if (!pa) begin
      if (q0.size() != 0 && q1.size() != 0) g = (last_g == 0) ? 1 : 0;
      else if (q0.size() != 0) g = 0;
      else if (q1.size() != 0) g = 1;
    end
    m_push_out = (g >= 0);
    if (g == 0) begin
      w = q0.pop_front();
      m_data_out = w;
      exp_q.push_back(w);
      last_g = 0;
    end else if (g == 1) begin
      w = q1.pop_front();
      m_data_out = w;
      exp_q.push_back(w);
      last_g = 1;
    end
    if (p0) begin
      if (!full0 || g == 0) q0.push_back(d0);
      else m_err0 = 1'b1;
    end
    if (p1) begin
      if (!full1 || g == 1) q1.push_back(d1);
      else m_err1 = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic pa);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, pa);
  endtask

  logic [W-1:0] order35 [4];
  logic [W-1:0] frozen;

  initial begin
    reset        = 1'b0;
    bus.push0    = 1'b0;
    bus.push1    = 1'b0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;
    bus.pause_in = 1'b0;
    seen_3f      = 1'b0;
    model_reset();
    #12;
    do_reset();

    // single word: visible one cycle after the write edge
    step(1'b1, 6'h05, 1'b0, '0, 1'b0);
    chk("r34_not_yet", 32'(bus.push_out), 32'd0);
    idle(1, 1'b0);
    chk("r34_push", 32'(bus.push_out), 32'd1);
    chk("r34_data", 32'(bus.data_out), 32'h05);
    idle(1, 1'b0);
    chk("r34_drop", 32'(bus.push_out), 32'd0);
    chk("r34_hold", 32'(bus.data_out), 32'h05);

    // alternation after preload under pause
    do_reset();
    order35[0] = 6'h11; order35[1] = 6'h21; order35[2] = 6'h12; order35[3] = 6'h22;
    step(1'b1, 6'h11, 1'b1, 6'h21, 1'b1);
    step(1'b1, 6'h12, 1'b1, 6'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      chk("r35_push", 32'(bus.push_out), 32'd1);
      chk("r35_order", 32'(bus.data_out), 32'(order35[i]));
    end
    idle(1, 1'b0);

    // fill S0, overflow with 0x3F
    do_reset();
    seen_3f = 1'b0;
    step(1'b1, 6'h01, 1'b0, '0, 1'b1);
    step(1'b1, 6'h02, 1'b0, '0, 1'b1);
    chk("r36_pause_off", 32'(bus.S0_pause), 32'd0);
    step(1'b1, 6'h03, 1'b0, '0, 1'b1);
    chk("r36_pause_on", 32'(bus.S0_pause), 32'd1);
    step(1'b1, 6'h04, 1'b0, '0, 1'b1);
    chk("r36_no_err_yet", 32'(bus.S0_wr_error), 32'd0);
    step(1'b1, 6'h3F, 1'b0, '0, 1'b1);
    chk("r36_err", 32'(bus.S0_wr_error), 32'd1);
    idle(6, 1'b0);
    chk("r36_no_3f", 32'(seen_3f), 32'd0);
    chk("r36_err_sticky", 32'(bus.S0_wr_error), 32'd1);

    // pause for 5 cycles with both sources loaded
    do_reset();
    step(1'b1, 6'h0A, 1'b1, 6'h1A, 1'b0);
    step(1'b1, 6'h0B, 1'b1, 6'h1B, 1'b0);
    frozen = bus.data_out;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      chk("r37_paused", 32'(bus.push_out), 32'd0);
      chk("r37_frozen", 32'(bus.data_out), 32'(frozen));
    end
    idle(1, 1'b0);
    chk("r37_resume", 32'(bus.push_out), 32'd1);
    idle(4, 1'b0);

    // reset mid-stream discards queued words
    do_reset();
    step(1'b1, 6'h31, 1'b1, 6'h32, 1'b1);
    step(1'b1, 6'h33, 1'b0, '0, 1'b1);
    idle(1, 1'b0);
    chk("r38_busy", 32'(bus.push_out), 32'd1);
    do_reset();
    idle(4, 1'b0);
    chk("r38_silent", 32'(bus.push_out), 32'd0);

    // push into full S0 while S0 is being popped
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, W'(6'h20 + i), 1'b0, '0, 1'b1);
    step(1'b1, 6'h2A, 1'b0, '0, 1'b0);
    chk("r39_no_err", 32'(bus.S0_wr_error), 32'd0);
    chk("r39_still_full", 32'(bus.S0_pause), 32'd1);
    idle(6, 1'b0);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 45), W'($urandom_range(0, 63)),
           1'($urandom_range(0, 99) < 45), W'($urandom_range(0, 63)),
           1'($urandom_range(0, 99) < 25));
    end
    idle(12, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("model_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
